// File: rtl/mem_pkg.sv
// Shared CPU defines: exe and mem op codes, the mem-stage
// FSM state encoding and the default memory-access timeout.
package mem_pkg;

    localparam logic [3:0] EXE_ADD = 4'h0;
    localparam logic [3:0] EXE_SUB = 4'h1;
    localparam logic [3:0] EXE_AND = 4'h2;
    localparam logic [3:0] EXE_OR  = 4'h3;
    localparam logic [3:0] EXE_XOR = 4'h4;
    localparam logic [3:0] EXE_SLL = 4'h5;
    localparam logic [3:0] EXE_SRL = 4'h6;

    localparam logic [2:0] MEM_PASS = 3'b000;
    localparam logic [2:0] MEM_LW   = 3'b001;
    localparam logic [2:0] MEM_SW   = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    localparam int MEM_TIMEOUT = 15;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == MEM_LW) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem.sv
// Memory stage: passes ALU results to writeback and runs a
// single outstanding LW/SW against the RAM with an ack timeout.
module mem
    import mem_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  aluop_i,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] sdata_i,
    output logic        stallreq,
    output logic        we_o,
    output logic [3:0]  waddr_o,
    output logic [15:0] wdata_o,
    output logic        err_o,
    output logic        ram_req,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [15:0] ram_rdata
);

    localparam logic [3:0] TMO = 4'(TIMEOUT);

    mem_state_e  r_state;
    mem_state_e  w_state_nx;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nx;
    logic        r_we;
    logic        w_we_nx;
    logic [3:0]  r_waddr;
    logic [3:0]  w_waddr_nx;
    logic        w_we_o;
    logic [3:0]  w_waddr_o;
    logic [15:0] w_wdata_o;
    logic        w_err;
    logic        w_req;
    logic        w_ram_we;
    logic [15:0] w_ram_addr;
    logic [15:0] w_ram_wdata;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_we_nx     = r_we;
        w_waddr_nx  = r_waddr;
        w_we_o      = 1'b0;
        w_waddr_o   = waddr_o;
        w_wdata_o   = wdata_o;
        w_err       = 1'b0;
        w_req       = ram_req;
        w_ram_we    = ram_we;
        w_ram_addr  = ram_addr;
        w_ram_wdata = ram_wdata;
        stallreq    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (is_mem_op(aluop_i)) begin
                    stallreq    = 1'b1;
                    w_req       = 1'b1;
                    w_ram_we    = (aluop_i == MEM_SW);
                    w_ram_addr  = wdata_i;
                    w_ram_wdata = sdata_i;
                    w_we_nx     = we_i;
                    w_waddr_nx  = waddr_i;
                    w_cnt_nx    = '0;
                    w_state_nx  = ST_BUSY;
                end else begin
                    w_we_o    = we_i;
                    w_waddr_o = waddr_i;
                    w_wdata_o = wdata_i;
                end
            end
            ST_BUSY: begin
                // An ack on the timeout cycle still completes the access
                if (ram_ack) begin
                    w_req      = 1'b0;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                    if (!ram_we) begin
                        w_we_o    = r_we;
                        w_waddr_o = r_waddr;
                        w_wdata_o = ram_rdata;
                    end
                end else if (r_cnt == TMO) begin
                    w_req      = 1'b0;
                    w_err      = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    stallreq = 1'b1;
                    w_cnt_nx = r_cnt + 4'd1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        if (rst) begin
            stallreq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            we_o      <= 1'b0;
            waddr_o   <= '0;
            wdata_o   <= '0;
            err_o     <= 1'b0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_we      <= w_we_nx;
            r_waddr   <= w_waddr_nx;
            we_o      <= w_we_o;
            waddr_o   <= w_waddr_o;
            wdata_o   <= w_wdata_o;
            err_o     <= w_err;
            ram_req   <= w_req;
            ram_we    <= w_ram_we;
            ram_addr  <= w_ram_addr;
            ram_wdata <= w_ram_wdata;
        end
    end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for the mem stage: directed table,
// hand-written corner sequences and randomized ops vs a model.
module tb_mem;

    localparam int TMO = 15;
    localparam logic [2:0] PASS = 3'b000;
    localparam logic [2:0] LW   = 3'b001;
    localparam logic [2:0] SW   = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  aluop_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  waddr_i = '0;
    logic [15:0] wdata_i = '0;
    logic [15:0] sdata_i = '0;
    logic        ram_ack = 1'b0;
    logic [15:0] ram_rdata = '0;
    logic        stallreq;
    logic        we_o;
    logic [3:0]  waddr_o;
    logic [15:0] wdata_o;
    logic        err_o;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;

    mem #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .aluop_i   (aluop_i),
        .we_i      (we_i),
        .waddr_i   (waddr_i),
        .wdata_i   (wdata_i),
        .sdata_i   (sdata_i),
        .stallreq  (stallreq),
        .we_o      (we_o),
        .waddr_o   (waddr_o),
        .wdata_o   (wdata_o),
        .err_o     (err_o),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_ack   (ram_ack),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          reqc;
        int          stalls;
        logic        we;
        logic        dchk;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        err;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [15:0] sd;
        int          ack_at;
        logic [15:0] rd;
        exp_t        e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ack_at: busy cycle (1-based) in which RAM acks; 0 = never
    function automatic exp_t model(input vec_t v);
        exp_t e;
        logic memop;
        logic done;
        memop = (v.op == LW) || (v.op == SW);
        done  = (v.ack_at >= 1) && (v.ack_at <= TMO + 1);
        if (!memop) begin
            e.reqc = 0; e.stalls = 0; e.err = 1'b0;
            e.we = v.we; e.dchk = 1'b1; e.wa = v.wa; e.wd = v.wd;
        end else begin
            e.reqc   = done ? v.ack_at : TMO + 1;
            e.stalls = e.reqc;
            e.err    = !done;
            e.we     = done && (v.op == LW) && v.we;
            e.dchk   = done && (v.op == LW);
            e.wa     = v.wa;
            e.wd     = v.rd;
        end
        return e;
    endfunction

    function automatic vec_t mk(
        input logic [2:0] op, input logic we, input logic [3:0] wa,
        input logic [15:0] wd, input logic [15:0] sd, input int ack,
        input logic [15:0] rd, input int reqc, input int stalls,
        input logic xwe, input logic dchk, input logic [3:0] xwa,
        input logic [15:0] xwd, input logic xerr);
        vec_t v;
        v.op = op; v.we = we; v.wa = wa; v.wd = wd; v.sd = sd;
        v.ack_at = ack; v.rd = rd;
        v.e.reqc = reqc; v.e.stalls = stalls; v.e.we = xwe;
        v.e.dchk = dchk; v.e.wa = xwa; v.e.wd = xwd; v.e.err = xerr;
        return v;
    endfunction

    // Entered and left at posedge+1; next op may be driven at once
    task automatic run_op(input vec_t v, input string nm);
        int stalls;
        int reqc;
        stalls  = 0;
        reqc    = 0;
        aluop_i = v.op;
        we_i    = v.we;
        waddr_i = v.wa;
        wdata_i = v.wd;
        sdata_i = v.sd;
        ram_ack = 1'b0;
        @(negedge clk);
        if (stallreq) stalls++;
        @(posedge clk); #1;
        while (ram_req && reqc < 20) begin
            reqc++;
            chk({nm, "_addr"}, ram_addr, v.wd);
            chk({nm, "_rwe"}, ram_we, v.op == SW);
            chk({nm, "_rwd"}, ram_wdata, v.sd);
            chk({nm, "_bubble"}, we_o, 1'b0);
            chk({nm, "_noerr"}, err_o, 1'b0);
            ram_ack   = (reqc == v.ack_at);
            ram_rdata = ram_ack ? v.rd : 16'($urandom);
            @(negedge clk);
            if (stallreq) stalls++;
            @(posedge clk); #1;
            ram_ack = 1'b0;
        end
        chk({nm, "_reqc"}, reqc, v.e.reqc);
        chk({nm, "_stalls"}, stalls, v.e.stalls);
        chk({nm, "_we"}, we_o, v.e.we);
        chk({nm, "_err"}, err_o, v.e.err);
        if (v.e.dchk) begin
            chk({nm, "_waddr"}, waddr_o, v.e.wa);
            chk({nm, "_wdata"}, wdata_o, v.e.wd);
        end
    endtask

    vec_t tv[9];
    vec_t rv;
    int   c1;
    int   k;

    initial begin
        tv[0] = mk(PASS, 1, 4'd1, 16'h0009, 16'h0, 0, 16'h0,
                   0, 0, 1, 1, 4'd1, 16'h0009, 0);
        tv[1] = mk(LW, 1, 4'd3, 16'h0040, 16'h0, 1, 16'hBEEF,
                   1, 1, 1, 1, 4'd3, 16'hBEEF, 0);
        tv[2] = mk(SW, 1, 4'd2, 16'h0010, 16'h1234, 3, 16'h0,
                   3, 3, 0, 0, 4'd0, 16'h0, 0);
        tv[3] = mk(LW, 1, 4'd5, 16'h0044, 16'h0, 0, 16'h0,
                   16, 16, 0, 0, 4'd0, 16'h0, 1);
        tv[4] = mk(LW, 1, 4'd7, 16'h0048, 16'h0, 16, 16'h5A5A,
                   16, 16, 1, 1, 4'd7, 16'h5A5A, 0);
        tv[5] = mk(3'b111, 1, 4'd9, 16'h7777, 16'h0, 0, 16'h0,
                   0, 0, 1, 1, 4'd9, 16'h7777, 0);
        tv[6] = mk(PASS, 0, 4'd2, 16'h1111, 16'h0, 0, 16'h0,
                   0, 0, 0, 1, 4'd2, 16'h1111, 0);
        tv[7] = mk(SW, 0, 4'd1, 16'h0050, 16'hAAAA, 0, 16'h0,
                   16, 16, 0, 0, 4'd0, 16'h0, 1);
        tv[8] = mk(LW, 0, 4'd4, 16'h0054, 16'h0, 2, 16'hCAFE,
                   2, 2, 0, 1, 4'd4, 16'hCAFE, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", we_o, 1'b0);
        chk("rst_waddr", waddr_o, 4'd0);
        chk("rst_wdata", wdata_o, 16'h0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_req", ram_req, 1'b0);
        chk("rst_rwe", ram_we, 1'b0);
        chk("rst_addr", ram_addr, 16'h0);
        chk("rst_rwd", ram_wdata, 16'h0);
        aluop_i = LW;
        @(negedge clk);
        chk("rst_stall", stallreq, 1'b0);
        @(posedge clk); #1;
        chk("rst_noissue", ram_req, 1'b0);
        aluop_i = PASS;
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op(tv[i], $sformatf("tv%0d", i));

        run_op(tv[1], "b2b_lw");
        c1 = cyc;
        run_op(tv[0], "b2b_pass");
        chk("b2b_gap", cyc - c1, 1);

        aluop_i = PASS; we_i = 1; waddr_i = 4'd8; wdata_i = 16'h00AA;
        ram_ack = 1'b1; ram_rdata = 16'hDEAD;
        @(negedge clk);
        chk("idle_ack_stall", stallreq, 1'b0);
        @(posedge clk); #1;
        chk("idle_ack_req", ram_req, 1'b0);
        chk("idle_ack_wdata", wdata_o, 16'h00AA);
        ram_ack = 1'b0;

        aluop_i = LW; we_i = 1; waddr_i = 4'd6; wdata_i = 16'h0020;
        @(posedge clk); #1;
        chk("rb_busy1", ram_req, 1'b1);
        @(posedge clk); #1;
        chk("rb_busy2", ram_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rb_stall", stallreq, 1'b0);
        @(posedge clk); #1;
        chk("rb_req", ram_req, 1'b0);
        chk("rb_we", we_o, 1'b0);
        chk("rb_err", err_o, 1'b0);
        chk("rb_stall2", stallreq, 1'b0);
        rst = 1'b0;
        run_op(tv[0], "rb_pass");

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 3);
            rv.op = (k == 1) ? LW : (k == 2) ? SW : 3'($urandom);
            rv.we = 1'($urandom);
            rv.wa = 4'($urandom);
            rv.wd = 16'($urandom);
            rv.sd = 16'($urandom);
            rv.rd = 16'($urandom);
            k = $urandom_range(0, 5);
            rv.ack_at = (k == 0) ? 0 : (k == 1) ? 16 : $urandom_range(1, 4);
            rv.e = model(rv);
            run_op(rv, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
